triangle_fetch: RTL and testbench

Consumer-side front end for the projected-triangle FIFO. It pops screen-space triangles written by the projection stage and discards degenerate, back-facing (optional) and fully off-screen triangles. Each surviving triangle is presented, with its bounding box, to the rasterizer over a valid/ready handshake. It keeps per-frame accepted and culled counts and pulses done once the FIFO has drained.

---
 rtl/triangle_fetch.sv | 163 ++++++++++++++++
 tb/tb_triangle_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_fetch.sv
// triangle_fetch
//   Consumer-side front end of the projected-triangle FIFO. Pops screen-space
//   triangles, drops degenerate / optionally back-facing / fully off-screen
//   ones, and hands survivors plus their bounding box to the rasterizer over
//   a valid/ready handshake. Keeps per-pass accepted and culled counts and
//   pulses fetch_done once the FIFO has drained.
//
// Ports
//   Clk, Reset        clock, asynchronous active-high reset
//   fetch_start       one-cycle pulse, starts a drain pass (honoured in IDLE)
//   fifo_empty        FIFO empty flag
//   fifo_r            FIFO pop strobe (read latency 1)
//   triangle_data     FIFO head, [v][0]=x, [v][1]=y, unsigned 10-bit
//   tri_valid/ready   rasterizer handshake
//   tri_out           registered triangle presented to the rasterizer
//   bbox_*            bounding box of tri_out
//   tri_count         triangles handed off this pass (saturating)
//   cull_count        triangles discarded this pass (saturating)
//   fetch_done        one-cycle pulse at the end of a pass
module triangle_fetch #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int CULL_BACK = 0,
  parameter int CW        = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 fetch_start,
  input  logic                 fifo_empty,
  output logic                 fifo_r,
  input  logic [2:0][1:0][9:0] triangle_data,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [2:0][1:0][9:0] tri_out,
  output logic [9:0]           bbox_min_x,
  output logic [9:0]           bbox_min_y,
  output logic [9:0]           bbox_max_x,
  output logic [9:0]           bbox_max_y,
  output logic [CW-1:0]        tri_count,
  output logic [CW-1:0]        cull_count,
  output logic                 fetch_done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, HOLD, DONE} state_t;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  state_t state;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Difference of two unsigned coordinates, widened so it never wraps.
  function automatic logic signed [10:0] sdiff(input logic [9:0] a, input logic [9:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic signed [10:0] dx1, dy1, dx2, dy2;
  logic signed [21:0] prod_a, prod_b;
  logic signed [22:0] area;
  logic [9:0]         min_x, min_y, max_x, max_y;
  logic               cull;

  // Evaluation of the registered triangle (used in EVAL)
  always_comb begin
    dx1    = sdiff(tri_out[1][0], tri_out[0][0]);
    dy1    = sdiff(tri_out[1][1], tri_out[0][1]);
    dx2    = sdiff(tri_out[2][0], tri_out[0][0]);
    dy2    = sdiff(tri_out[2][1], tri_out[0][1]);
    prod_a = dx1 * dy2;
    prod_b = dx2 * dy1;
    area   = {prod_a[21], prod_a} - {prod_b[21], prod_b};
    min_x  = min3(tri_out[0][0], tri_out[1][0], tri_out[2][0]);
    min_y  = min3(tri_out[0][1], tri_out[1][1], tri_out[2][1]);
    max_x  = max3(tri_out[0][0], tri_out[1][0], tri_out[2][0]);
    max_y  = max3(tri_out[0][1], tri_out[1][1], tri_out[2][1]);
    cull   = (area == '0)
          || ((CULL_BACK != 0) && area[22])
          || ({1'b0, min_x} >= H_LIM)
          || ({1'b0, min_y} >= V_LIM);
  end

  // Pop is gated by the live empty flag so an empty FIFO is never read.
  assign fifo_r = (state == REQ) && !fifo_empty;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      tri_valid  <= 1'b0;
      fetch_done <= 1'b0;
      tri_out    <= '0;
      bbox_min_x <= '0;
      bbox_min_y <= '0;
      bbox_max_x <= '0;
      bbox_max_y <= '0;
      tri_count  <= '0;
      cull_count <= '0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            tri_count  <= '0;
            cull_count <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (fifo_empty) begin
            fetch_done <= 1'b1;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        // FIFO head is valid one cycle after the pop
        WAIT: begin
          tri_out <= triangle_data;
          state   <= EVAL;
        end
        EVAL: begin
          if (cull) begin
            cull_count <= sat_inc(cull_count);
            state      <= REQ;
          end else begin
            bbox_min_x <= min_x;
            bbox_min_y <= min_y;
            bbox_max_x <= max_x;
            bbox_max_y <= max_y;
            tri_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (tri_ready) begin
            tri_valid <= 1'b0;
            tri_count <= sat_inc(tri_count);
            state     <= REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_fetch.sv
// Bench for triangle_fetch: instance A (CULL_BACK=0, CW=8) is checked every
// cycle against a behavioural model fed from the bench FIFO contents;
// instance B (CULL_BACK=1, CW=2) covers back-face culling and saturation.
module tb_triangle_fetch;
  typedef logic [2:0][1:0][9:0] tri_t;
  typedef struct { tri_t t; logic [39:0] bb; } exp_t;

  logic Clk, Reset;

  logic fetch_start_a, fifo_empty_a, fifo_r_a, tri_valid_a, tri_ready_a, fetch_done_a;
  tri_t triangle_data_a = '0;
  tri_t tri_out_a;
  logic [9:0] bbox_min_x_a, bbox_min_y_a, bbox_max_x_a, bbox_max_y_a;
  logic [7:0] tri_count_a, cull_count_a;

  logic fetch_start_b, fifo_empty_b, fifo_r_b, tri_valid_b, tri_ready_b, fetch_done_b;
  tri_t triangle_data_b = '0;
  tri_t tri_out_b;
  logic [9:0] bbox_min_x_b, bbox_min_y_b, bbox_max_x_b, bbox_max_y_b;
  logic [1:0] tri_count_b, cull_count_b;

  triangle_fetch #(.H_RES(640), .V_RES(480), .CULL_BACK(0), .CW(8)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .fetch_start(fetch_start_a), .fifo_empty(fifo_empty_a),
    .fifo_r(fifo_r_a), .triangle_data(triangle_data_a), .tri_valid(tri_valid_a),
    .tri_ready(tri_ready_a), .tri_out(tri_out_a), .bbox_min_x(bbox_min_x_a),
    .bbox_min_y(bbox_min_y_a), .bbox_max_x(bbox_max_x_a), .bbox_max_y(bbox_max_y_a),
    .tri_count(tri_count_a), .cull_count(cull_count_a), .fetch_done(fetch_done_a));

  triangle_fetch #(.H_RES(640), .V_RES(480), .CULL_BACK(1), .CW(2)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .fetch_start(fetch_start_b), .fifo_empty(fifo_empty_b),
    .fifo_r(fifo_r_b), .triangle_data(triangle_data_b), .tri_valid(tri_valid_b),
    .tri_ready(tri_ready_b), .tri_out(tri_out_b), .bbox_min_x(bbox_min_x_b),
    .bbox_min_y(bbox_min_y_b), .bbox_max_x(bbox_max_x_b), .bbox_max_y(bbox_max_y_b),
    .tri_count(tri_count_b), .cull_count(cull_count_b), .fetch_done(fetch_done_b));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO models, read latency 1
  tri_t mem_a[64];
  tri_t mem_b[64];
  int push_a = 0, pop_a = 0, push_b = 0, pop_b = 0;
  assign fifo_empty_a = (push_a == pop_a);
  assign fifo_empty_b = (push_b == pop_b);

  always @(posedge Clk) begin
    if (fifo_r_a) begin
      triangle_data_a <= mem_a[pop_a % 64];
      pop_a <= pop_a + 1;
    end
  end

  always @(posedge Clk) begin
    if (fifo_r_b) begin
      triangle_data_b <= mem_b[pop_b % 64];
      pop_b <= pop_b + 1;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2);
    tri_t t;
    t[0][0] = 10'(x0); t[0][1] = 10'(y0);
    t[1][0] = 10'(x1); t[1][1] = 10'(y1);
    t[2][0] = 10'(x2); t[2][1] = 10'(y2);
    return t;
  endfunction

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Reference rules: keep unless zero area, back-facing (when enabled) or off-screen.
  function automatic bit keep(input tri_t t, input bit cull_back);
    int x0, y0, x1, y1, x2, y2, area;
    x0 = int'(t[0][0]); y0 = int'(t[0][1]);
    x1 = int'(t[1][0]); y1 = int'(t[1][1]);
    x2 = int'(t[2][0]); y2 = int'(t[2][1]);
    area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
    if (area == 0) return 1'b0;
    if (cull_back && area < 0) return 1'b0;
    if (imin3(x0, x1, x2) >= 640) return 1'b0;
    if (imin3(y0, y1, y2) >= 480) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t mk_exp(input tri_t t);
    exp_t e;
    e.t  = t;
    e.bb = {10'(imin3(int'(t[0][0]), int'(t[1][0]), int'(t[2][0]))),
            10'(imin3(int'(t[0][1]), int'(t[1][1]), int'(t[2][1]))),
            10'(imax3(int'(t[0][0]), int'(t[1][0]), int'(t[2][0]))),
            10'(imax3(int'(t[0][1]), int'(t[1][1]), int'(t[2][1])))};
    return e;
  endfunction

  // Compare process for instance A
  exp_t exp_q[$];
  int exp_cull = 0, hs_pass = 0, start_cyc = 0, valid_cyc = 0, hs_cyc = 0;
  int done_cyc = 0, pop_cyc = 0, n_done_a = 0;
  bit prev_valid = 1'b0, prev_hs = 1'b0;
  tri_t prev_tri = '0;
  logic [39:0] cap_bb = '0;

  always @(negedge Clk) begin
    if (Reset) begin
      check("rst_tri_valid", tri_valid_a, 0);
      check("rst_fifo_r", fifo_r_a, 0);
      check("rst_tri_out", tri_out_a, 0);
      check("rst_bbox", {bbox_min_x_a, bbox_min_y_a, bbox_max_x_a, bbox_max_y_a}, 0);
      check("rst_counts", {tri_count_a, cull_count_a}, 0);
      check("rst_fetch_done", fetch_done_a, 0);
      exp_q.delete();
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (fetch_start_a) begin
        start_cyc = cyc;
        hs_pass = 0;
        exp_cull = 0;
        exp_q.delete();
      end
      if (fifo_r_a) begin
        check("fifo_r_while_empty", fifo_empty_a, 0);
        pop_cyc = cyc;
        if (keep(mem_a[pop_a % 64], 1'b0)) exp_q.push_back(mk_exp(mem_a[pop_a % 64]));
        else exp_cull++;
      end
      if (prev_valid && !prev_hs) begin
        check("valid_held", tri_valid_a, 1);
        check("tri_out_stable", tri_out_a, prev_tri);
      end
      if (tri_valid_a) begin
        if (!prev_valid) valid_cyc = cyc;
        cap_bb = {bbox_min_x_a, bbox_min_y_a, bbox_max_x_a, bbox_max_y_a};
        if (exp_q.size() == 0) check("valid_without_triangle", tri_valid_a, 0);
        else begin
          check("tri_out", tri_out_a, exp_q[0].t);
          check("bbox", cap_bb, exp_q[0].bb);
        end
      end
      prev_valid = tri_valid_a;
      prev_tri = tri_out_a;
      prev_hs = tri_valid_a && tri_ready_a;
      if (prev_hs) begin
        hs_pass++;
        hs_cyc = cyc;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (fetch_done_a) begin
        done_cyc = cyc;
        n_done_a++;
        check("tri_count", tri_count_a, hs_pass);
        check("cull_count", cull_count_a, exp_cull);
        check("model_drained", exp_q.size(), 0);
      end
    end
  end

  // Event counters for instance B
  int n_valid_b = 0, n_hs_b = 0, n_done_b = 0;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (fifo_r_b) check("b_fifo_r_while_empty", fifo_empty_b, 0);
      if (tri_valid_b) n_valid_b++;
      if (tri_valid_b && tri_ready_b) n_hs_b++;
      if (fetch_done_b) n_done_b++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_a(input tri_t t);
    mem_a[push_a % 64] = t;
    push_a++;
  endtask

  task automatic put_b(input tri_t t);
    mem_b[push_b % 64] = t;
    push_b++;
  endtask

  task automatic wait_done_a(input int d0, input int lim);
    int k;
    k = 0;
    while (n_done_a == d0 && k < lim) begin
      tick();
      k++;
    end
    if (n_done_a == d0) check("pass_a_timeout", fetch_done_a, 1);
  endtask

  task automatic run_a(input int lim);
    int d0;
    d0 = n_done_a;
    fetch_start_a = 1'b1;
    tick();
    fetch_start_a = 1'b0;
    wait_done_a(d0, lim);
  endtask

  task automatic run_b(input int lim);
    int d0, k;
    d0 = n_done_b;
    k = 0;
    fetch_start_b = 1'b1;
    tick();
    fetch_start_b = 1'b0;
    while (n_done_b == d0 && k < lim) begin
      tick();
      k++;
    end
    if (n_done_b == d0) check("pass_b_timeout", fetch_done_b, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, h0, v0, k, rc;
    Reset = 1'b1;
    fetch_start_a = 1'b0; tri_ready_a = 1'b0;
    fetch_start_b = 1'b0; tri_ready_b = 1'b1;
    tick(); tick();
    check("reset_counts_b", {tri_count_b, cull_count_b, tri_valid_b, fetch_done_b}, 0);
    Reset = 1'b0;
    tick();

    // Accepted triangle
    p0 = pop_a;
    tri_ready_a = 1'b1;
    put_a(mk(10, 10, 20, 10, 10, 30));
    run_a(30);
    check("t1_valid_latency", valid_cyc - start_cyc, 4);
    check("t1_pop_latency", pop_cyc - start_cyc, 1);
    check("t1_pops", pop_a - p0, 1);
    check("t1_bbox", cap_bb, {10'd10, 10'd10, 10'd20, 10'd30});
    check("t1_done_after_hs", done_cyc - hs_cyc, 2);
    check("t1_counts", {tri_count_a, cull_count_a}, {8'd1, 8'd0});
    repeat (3) tick();
    check("t1_counts_hold", {tri_count_a, cull_count_a}, {8'd1, 8'd0});

    // Degenerate, off-screen in y, and on-screen x=639 boundary
    put_a(mk(0, 0, 5, 5, 10, 10));
    put_a(mk(5, 480, 20, 490, 5, 500));
    put_a(mk(639, 0, 700, 0, 639, 20));
    run_a(60);
    check("t2_counts", {tri_count_a, cull_count_a}, {8'd1, 8'd2});
    check("t2_bbox", cap_bb, {10'd639, 10'd0, 10'd700, 10'd20});

    // Clockwise winding kept when back-face culling is off
    put_a(mk(10, 10, 10, 30, 20, 10));
    run_a(30);
    check("t3_counts_a", {tri_count_a, cull_count_a}, {8'd1, 8'd0});

    // Same winding culled when back-face culling is on
    v0 = n_valid_b;
    put_b(mk(10, 10, 10, 30, 20, 10));
    run_b(30);
    check("t3_counts_b", {tri_count_b, cull_count_b}, {2'd0, 2'd1});
    check("t3_no_valid_b", n_valid_b - v0, 0);

    // Off-screen in x followed by a kept triangle under backpressure
    tri_ready_a = 1'b0;
    put_a(mk(650, 10, 700, 10, 650, 50));
    put_a(mk(100, 200, 300, 220, 150, 400));
    p0 = n_done_a;
    fetch_start_a = 1'b1;
    tick();
    fetch_start_a = 1'b0;
    k = 0;
    while (!tri_valid_a && k < 30) begin
      tick();
      k++;
    end
    check("t4_valid", tri_valid_a, 1);
    repeat (4) tick();
    check("t4_still_valid", tri_valid_a, 1);
    check("t4_bbox", cap_bb, {10'd100, 10'd200, 10'd300, 10'd400});
    check("t4_valid_latency", valid_cyc - start_cyc, 7);
    tri_ready_a = 1'b1;
    rc = cyc;
    wait_done_a(p0, 30);
    check("t4_hs_on_ready", hs_cyc, rc);
    check("t4_counts", {tri_count_a, cull_count_a}, {8'd1, 8'd1});

    // Empty FIFO
    p0 = pop_a;
    run_a(10);
    check("t5_done_latency", done_cyc - start_cyc, 2);
    check("t5_counts", {tri_count_a, cull_count_a}, 0);
    check("t5_no_pop", pop_a - p0, 0);

    // Reset while holding a triangle
    tri_ready_a = 1'b0;
    p0 = pop_a;
    put_a(mk(10, 10, 20, 10, 10, 30));
    put_a(mk(30, 40, 90, 40, 30, 100));
    fetch_start_a = 1'b1;
    tick();
    fetch_start_a = 1'b0;
    k = 0;
    while (!tri_valid_a && k < 30) begin
      tick();
      k++;
    end
    check("t6_valid_before_reset", tri_valid_a, 1);
    check("t6_one_pop", pop_a - p0, 1);
    Reset = 1'b1;
    #1;
    check("t6_rst_valid", tri_valid_a, 0);
    check("t6_rst_tri_out", tri_out_a, 0);
    check("t6_rst_bbox", {bbox_min_x_a, bbox_min_y_a, bbox_max_x_a, bbox_max_y_a}, 0);
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    check("t6_no_more_pop", pop_a - p0, 1);
    check("t6_idle", {tri_valid_a, fifo_r_a}, 0);
    tri_ready_a = 1'b1;
    run_a(30);
    check("t6_leftover_delivered", pop_a - p0, 2);
    check("t6_counts", {tri_count_a, cull_count_a}, {8'd1, 8'd0});
    check("t6_bbox", cap_bb, {10'd30, 10'd40, 10'd90, 10'd100});
    check("t6_fifo_empty", fifo_empty_a, 1);

    // Saturation with CW=2
    tri_ready_b = 1'b1;
    h0 = n_hs_b;
    for (int i = 0; i < 5; i++) put_b(mk(10, 10, 20, 10, 10, 30));
    run_b(100);
    check("t7_handshakes", n_hs_b - h0, 5);
    check("t7_counts_b", {tri_count_b, cull_count_b}, {2'd3, 2'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
